// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: width defaults,
// FSM state encodings and read-owner tag encodings.
package mem_arbiter_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 64;

  typedef enum logic {
    ST_IDLE        = 1'b0,
    ST_OWN_M1_LOCK = 1'b1
  } state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM with m1 bus locking.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_lock,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m0_rdata,
  output logic [DW-1:0]   m1_rdata,
  output logic            ram_ce,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wstrb,
  input  logic [DW-1:0]   ram_rdata
);

  state_t        state_reg, state_next;
  owner_t        owner_reg;
  logic          rd_pending_reg;
  logic [DW-1:0] m0_hold_reg, m1_hold_reg;

`ifdef MEM_ARB_RR_EN
  // Last master granted; reset to m1 so that m0 wins the first contention.
  owner_t last_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg <= OWN_M1;
    end else if (m0_gnt || m1_gnt) begin
      last_reg <= m1_gnt ? OWN_M1 : OWN_M0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grants are gated by reset so nothing is accepted while rst is low.
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    state_next = state_reg;
    if (rst) begin
      case (state_reg)
        ST_IDLE: begin
          if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
            if (last_reg == OWN_M0) m1_gnt = 1'b1;
            else                    m0_gnt = 1'b1;
`else
            m0_gnt = 1'b1;
`endif
          end else if (m0_req) begin
            m0_gnt = 1'b1;
          end else if (m1_req) begin
            m1_gnt = 1'b1;
          end
          if (m1_gnt && m1_lock) state_next = ST_OWN_M1_LOCK;
        end
        ST_OWN_M1_LOCK: begin
          m1_gnt = m1_req;
          if (!m1_lock) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    if (m0_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_wstrb = m0_wstrb;
    end else if (m1_gnt) begin
      ram_ce    = 1'b1;
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_wstrb = m1_wstrb;
    end
  end

  // Owner tag is captured with the read so the return can be steered next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pending_reg <= 1'b0;
      owner_reg      <= OWN_M0;
    end else begin
      rd_pending_reg <= ram_ce && !ram_we;
      if (ram_ce) owner_reg <= m1_gnt ? OWN_M1 : OWN_M0;
    end
  end

  assign m0_rvalid = rd_pending_reg && (owner_reg == OWN_M0);
  assign m1_rvalid = rd_pending_reg && (owner_reg == OWN_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_hold_reg <= '0;
      m1_hold_reg <= '0;
    end else begin
      if (m0_rvalid) m0_hold_reg <= ram_rdata;
      if (m1_rvalid) m1_hold_reg <= ram_rdata;
    end
  end

  assign m0_rdata = m0_rvalid ? ram_rdata : m0_hold_reg;
  assign m1_rdata = m1_rvalid ? ram_rdata : m1_hold_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a RAM model and a read-return scoreboard.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 64;

  logic            clk;
  logic            rst;
  logic            m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [DW-1:0]   m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb;
  logic            m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic            ram_ce, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW/8-1:0] ram_wstrb;
  logic [DW-1:0]   ram_rdata;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            total = 0;
  int            bad   = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    ram_rdata = '0;
  end

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < DW / 8; b++)
          if (ram_wstrb[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW / 8; b++)
      if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Scoreboard: pops read returns, pushes expectations for reads accepted this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb.delete();
    end else begin
      chk("one_rvalid", {63'd0, m0_rvalid && m1_rvalid}, 64'd0);
      chk("one_gnt", {63'd0, m0_gnt && m1_gnt}, 64'd0);
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {63'd0, m1_rvalid}, {63'd0, !m1_rvalid});
        end else begin
          e = sb.pop_front();
          chk("rvalid_port", {63'd0, m1_rvalid}, {63'd0, e.port});
          chk("rdata", m1_rvalid ? m1_rdata : m0_rdata, e.data);
        end
      end
      if (!m0_gnt && !m1_gnt) begin
        chk("ram_ce_idle", {63'd0, ram_ce}, 64'd0);
        chk("ram_addr_idle", {52'd0, ram_addr}, 64'd0);
        chk("ram_wdata_idle", ram_wdata, 64'd0);
      end else begin
        chk("ram_addr", {52'd0, ram_addr}, {52'd0, m1_gnt ? m1_addr : m0_addr});
        chk("ram_we", {63'd0, ram_we}, {63'd0, m1_gnt ? m1_we : m0_we});
      end
      if (m0_gnt) begin
        if (m0_we) ref_mem[m0_addr] = merge(ref_mem[m0_addr], m0_wdata, m0_wstrb);
        else begin e.port = 1'b0; e.data = ref_mem[m0_addr]; sb.push_back(e); end
      end
      if (m1_gnt) begin
        if (m1_we) ref_mem[m1_addr] = merge(ref_mem[m1_addr], m1_wdata, m1_wstrb);
        else begin e.port = 1'b1; e.data = ref_mem[m1_addr]; sb.push_back(e); end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    m1_lock = 0;
  endtask

  task automatic m0_drive(input logic we, input int addr, input logic [DW-1:0] d);
    m0_req = 1; m0_we = we; m0_addr = AW'(addr); m0_wdata = d; m0_wstrb = 8'hFF;
  endtask

  task automatic m1_drive(input logic we, input int addr, input logic [DW-1:0] d);
    m1_req = 1; m1_we = we; m1_addr = AW'(addr); m1_wdata = d; m1_wstrb = 8'hFF;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    #1;
    chk({tag, "_m0_gnt"}, {63'd0, m0_gnt}, {63'd0, g0});
    chk({tag, "_m1_gnt"}, {63'd0, m1_gnt}, {63'd0, g1});
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    // Reset held with m0 requesting a write of 0x123 to address 5.
    m0_drive(1, 5, 64'h123);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_gnt("reset", 0, 0);
      chk("reset_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
      chk("reset_m0_rdata", m0_rdata, 64'd0);
      chk("reset_m1_rdata", m1_rdata, 64'd0);
    end
    rst = 1;
    chk_gnt("release", 1, 0);

    cyc();
    idle_inputs();
    m1_drive(0, 5, '0);
    chk_gnt("m1_read5", 0, 1);
    cyc();
    idle_inputs();
    chk("m1_rvalid_after_gnt", {63'd0, m1_rvalid}, 64'd1);
    chk("m1_rdata_5", m1_rdata, 64'h123);
    chk("m0_rvalid_quiet", {63'd0, m0_rvalid}, 64'd0);
    cyc();
    chk("m1_rvalid_drop", {63'd0, m1_rvalid}, 64'd0);
    chk("m1_rdata_hold", m1_rdata, 64'h123);

    for (int i = 0; i < 4; i++) begin
      m0_drive(1, 10 + i, 64'hA5A5_0000_0000_0000 + 64'(i * 17 + 1));
      chk_gnt("m0_wr", 1, 0);
      cyc();
    end
    idle_inputs();

    // Partial-strobe write, then read it back with a new grant in the return cycle.
    m1_drive(1, 20, 64'hFFFF_FFFF_FFFF_FFFF);
    m1_wstrb = 8'h0F;
    chk_gnt("m1_strb_wr", 0, 1);
    cyc();
    idle_inputs();
    m1_drive(0, 20, '0);
    chk_gnt("m1_rd20", 0, 1);
    cyc();
    idle_inputs();
    m0_drive(0, 10, '0);
    chk_gnt("overlap_m0", 1, 0);
    chk("overlap_m1_rvalid", {63'd0, m1_rvalid}, 64'd1);
    chk("strb_rdata", m1_rdata, 64'h0000_0000_FFFF_FFFF);
    cyc();
    idle_inputs();
    m1_drive(0, 11, '0);
    chk_gnt("m1_rd11", 0, 1);
    chk("m0_rvalid_rd10", {63'd0, m0_rvalid}, 64'd1);
    cyc();

    idle_inputs();
    m0_drive(0, 12, '0);
    m1_drive(0, 13, '0);
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
      chk_gnt("contend_rr", (i % 2) == 0, (i % 2) == 1);
`else
      chk_gnt("contend_fixed", 1, 0);
`endif
      cyc();
    end
    idle_inputs();

    // m1 takes the lock while m0 is idle, then m0 contends through the drop cycle.
    m1_lock = 1;
    m1_drive(1, 30, 64'hC0DE_0000);
    chk_gnt("lock_wr0", 0, 1);
    for (int i = 1; i < 4; i++) begin
      cyc();
      m0_drive(0, 10, '0);
      m1_drive(1, 30 + i, 64'hC0DE_0000 + 64'(i));
      chk_gnt("lock_wr", 0, 1);
    end
    cyc();
    m1_req = 0;
    m1_lock = 0;
    chk_gnt("lock_drop", 0, 0);
    cyc();
    chk_gnt("after_lock", 1, 0);
    cyc();
    idle_inputs();
    m1_drive(0, 33, '0);
    chk_gnt("rd_lock_data", 0, 1);
    cyc();
    idle_inputs();
    chk("lock_rdata", m1_rdata, 64'hC0DE_0003);

    // Reset in the cycle after a read grant kills the return.
    m0_drive(0, 12, '0);
    chk_gnt("pre_rst_rd", 1, 0);
    cyc();
    idle_inputs();
    rst = 0;
    cyc();
    cyc();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
      chk("post_rst_m0_rdata", m0_rdata, 64'd0);
      cyc();
    end

    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 12, RAM word-address width (4096 x 64-bit words).
REQ-002 Parameter DW, default 64, data width; strobe width is DW/8.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 m0_req / m1_req  input  1  request valid, core LSU (m0) / loader-debug port (m1).
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_addr / m1_addr  input  AW  word address.
REQ-008 m0_wdata / m1_wdata  input  DW  write data.
REQ-009 m0_wstrb / m1_wstrb  input  DW/8  byte enables.
REQ-010 m1_lock  input  1  m1 holds ownership across consecutive transfers while high.
REQ-011 m0_gnt / m1_gnt  output  1  request accepted this cycle.
REQ-012 m0_rvalid / m1_rvalid  output  1  read data valid.
REQ-013 m0_rdata / m1_rdata  output  DW  read data.
REQ-014 ram_ce, ram_we  output  1  RAM enable / write enable.
REQ-015 ram_addr, ram_wdata, ram_wstrb  output  AW, DW, DW/8  RAM command.
REQ-016 ram_rdata  input  DW  RAM read data, one cycle after ram_ce with ram_we=0.

Function
REQ-017 Handshake: a requester SHALL hold req and all fields stable until gnt; transfer occurs in the gnt cycle.
REQ-018 gnt and ram_* SHALL be combinational from req and arbiter state; at most one gnt per cycle.
REQ-019 Read latency: mX_rvalid high exactly one cycle after mX_gnt on a read, with mX_rdata = ram_rdata; writes produce no rvalid.
REQ-020 A new grant SHALL be allowed in the rvalid cycle of the previous read (full throughput, one transfer per cycle).
REQ-021 Registered owner tag SHALL route rdata; the non-owner's rvalid stays 0 and its rdata holds its last value.
REQ-022 FSM states: IDLE, OWN_M1_LOCK.
REQ-023 IDLE: arbitrate per REQ-029/030; if m1 granted with m1_lock=1 -> OWN_M1_LOCK.
REQ-024 OWN_M1_LOCK: only m1 is granted; m0_gnt = 0 regardless of m0_req; m1_lock=0 -> IDLE the next cycle (that cycle still m1-only).
REQ-025 ram_ce = 0 and ram_* command fields = 0 when no grant.
REQ-026 No requests: state and round-robin pointer unchanged.
REQ-027 Simultaneous read return and new grant: rvalid to old owner, gnt to new winner, same cycle.

Reset
REQ-028 rst low: state = IDLE, rr pointer = favour m0, owner tag cleared, all gnt/rvalid = 0, rdata = 0; a read in flight is discarded and its rvalid never asserts.

Configuration
REQ-029 MEM_ARB_RR_EN defined: round-robin; on both requesting, winner is the master not granted last; pointer updates on every grant.
REQ-030 MEM_ARB_RR_EN undefined: fixed priority, m0 always wins in IDLE; rr pointer not instantiated.

Structure
REQ-031 Shared defines file holds AW/DW defaults, FSM state encodings and owner-tag encodings.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 Reset with m0_req=1 held: all gnt/rvalid 0 until rst released, then m0_gnt same cycle.
REQ-034 m0 write 0x123 @ addr 5, then m1 read @5: m1_rvalid one cycle after m1_gnt, m1_rdata = 0x123, m0_rvalid stays 0.
REQ-035 Both req reads every cycle, RR_EN defined: grants alternate m0,m1,m0,m1; undefined: m0 every cycle, m1 never.
REQ-036 m1_lock=1 for 4 writes with m0_req=1: m0_gnt=0 for all 4 cycles plus the lock-drop cycle, then m0 granted.
REQ-037 rst asserted the cycle after a read grant: no rvalid on either port after reset release.
